// File: rtl/timer_capture_collector.sv
// timer_capture_collector
// Collects per-interface timer captures into one stream. Each interface has a
// one-entry hold register with a pending flag. A round-robin arbiter moves at
// most one pending capture per cycle into a first-word fall-through FIFO. The
// FIFO drains as {interface index, captured value} over a valid/ready handshake.
// A capture that replaces a hold value before that value was queued sets a
// sticky per-interface overrun flag.

module timer_capture_collector #(
  parameter int TIMER_BITWIDTH = 32,
  parameter int NB_INTERFACES  = 10,
  parameter int FIFO_DEPTH     = 8,
  localparam int IDX_W         = (NB_INTERFACES > 1) ? $clog2(NB_INTERFACES) : 1,
  localparam int PTR_W         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
  localparam int LVL_W         = PTR_W + 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NB_INTERFACES-1:0]                cap_strobe,
  input  logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] captured,
  input  logic [NB_INTERFACES-1:0]                ovr_clr,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [IDX_W-1:0]                        out_idx,
  output logic [TIMER_BITWIDTH-1:0]               out_value,
  output logic [LVL_W-1:0]                        fifo_level,
  output logic                                    fifo_full,
  output logic [NB_INTERFACES-1:0]                overrun
);

  localparam int ENTRY_W = IDX_W + TIMER_BITWIDTH;
  localparam logic [LVL_W-1:0] LVL_MAX  = LVL_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB_INTERFACES - 1);

  // Capture stage state
  logic [NB_INTERFACES-1:0]  pend;
  logic [TIMER_BITWIDTH-1:0] hold [NB_INTERFACES];

  // Arbiter state and decision
  logic [IDX_W-1:0]          rr_ptr;
  logic                      grant_vld;
  logic [IDX_W-1:0]          grant_idx;
  logic [NB_INTERFACES-1:0]  grant_oh;
  logic [TIMER_BITWIDTH-1:0] grant_data;
  logic                      fifo_space;

  // FIFO state
  logic [ENTRY_W-1:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [ENTRY_W-1:0]        head;
  logic                      push;
  logic                      pop;

  // Space is judged on the pre-pop level: a same-cycle pop never makes room.
  assign fifo_space = (fifo_level < LVL_MAX);
  assign fifo_full  = (fifo_level == LVL_MAX);

  // Round-robin pick: first pending index at or above rr_ptr, otherwise the
  // first pending index below it (wrap-around search).
  always_comb begin
    logic found_hi;
    logic found_lo;
    logic [IDX_W-1:0] idx_hi;
    logic [IDX_W-1:0] idx_lo;
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int i = 0; i < NB_INTERFACES; i++) begin
      if (pend[i]) begin
        if (IDX_W'(i) >= rr_ptr) begin
          if (!found_hi) begin
            found_hi = 1'b1;
            idx_hi   = IDX_W'(i);
          end
        end else begin
          if (!found_lo) begin
            found_lo = 1'b1;
            idx_lo   = IDX_W'(i);
          end
        end
      end
    end
    grant_vld = fifo_space && (found_hi || found_lo);
    grant_idx = found_hi ? idx_hi : idx_lo;
  end

  // Decode the grant to a one-hot vector and select the hold value to queue.
  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int i = 0; i < NB_INTERFACES; i++) begin
      if (grant_vld && (grant_idx == IDX_W'(i))) begin
        grant_oh[i] = 1'b1;
        grant_data  = hold[i];
      end
    end
  end

  // Per-interface hold/pend/overrun update. A strobe on a granted interface
  // is a clean handoff: the old value leaves this cycle, the new one loads.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= '0;
      overrun <= '0;
      for (int i = 0; i < NB_INTERFACES; i++) begin
        hold[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB_INTERFACES; i++) begin
        if (cap_strobe[i]) begin
          hold[i] <= captured[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
          pend[i] <= 1'b1;
        end else if (grant_oh[i]) begin
          pend[i] <= 1'b0;
        end

        // Set wins over clear when both happen in the same cycle.
        if (cap_strobe[i] && pend[i] && !grant_oh[i]) begin
          overrun[i] <= 1'b1;
        end else if (ovr_clr[i]) begin
          overrun[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer advances past the winner; holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      rr_ptr <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
    end
  end

  assign push = grant_vld;
  assign pop  = out_valid && out_ready;

  // FIFO storage; contents need no reset because the outputs are gated by level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {grant_idx, grant_data};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Fall-through head; index and value read as zero when the FIFO is empty.
  always_comb begin
    head      = mem[rd_ptr];
    out_valid = (fifo_level != '0);
    out_idx   = '0;
    out_value = '0;
    if (out_valid) begin
      out_idx   = head[TIMER_BITWIDTH +: IDX_W];
      out_value = head[TIMER_BITWIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_timer_capture_collector.sv
// Bench for timer_capture_collector: directed scenarios plus random traffic,
// all compared every cycle against a queue-based behavioural model.

module tb_timer_capture_collector;

  localparam int TW    = 32;
  localparam int NB    = 10;
  localparam int DEPTH = 8;
  localparam int IDX_W = $clog2(NB);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NB-1:0]        cap_strobe;
  logic [TW*NB-1:0]     captured;
  logic [NB-1:0]        ovr_clr;
  logic                 out_valid;
  logic                 out_ready;
  logic [IDX_W-1:0]     out_idx;
  logic [TW-1:0]        out_value;
  logic [LVL_W-1:0]     fifo_level;
  logic                 fifo_full;
  logic [NB-1:0]        overrun;

  int n_chk = 0;
  int n_err = 0;

  // Behavioural model: pending flags, hold values, overrun, rr pointer, FIFO queue
  bit                    m_pend [NB];
  logic [TW-1:0]         m_hold [NB];
  logic [NB-1:0]         m_ovr;
  int                    m_rr;
  logic [IDX_W+TW-1:0]   m_q [$];

  timer_capture_collector #(
    .TIMER_BITWIDTH(TW),
    .NB_INTERFACES (NB),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cap_strobe(cap_strobe),
    .captured  (captured),
    .ovr_clr   (ovr_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_value (out_value),
    .fifo_level(fifo_level),
    .fifo_full (fifo_full),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_slice(input int i, input logic [TW-1:0] v);
    captured[i*TW +: TW] = v;
  endtask

  // Advance the model by one clock using the inputs applied for this edge.
  task automatic model_update();
    int g;
    int c;
    logic [IDX_W-1:0] gi;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_pend[i] = 1'b0;
        m_hold[i] = '0;
      end
      m_ovr = '0;
      m_rr  = 0;
      m_q.delete();
    end else begin
      g = -1;
      if (m_q.size() < DEPTH) begin
        for (int k = 0; k < NB; k++) begin
          c = (m_rr + k) % NB;
          if (g < 0 && m_pend[c]) g = c;
        end
      end
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (g >= 0) begin
        gi = g[IDX_W-1:0];
        m_q.push_back({gi, m_hold[g]});
        m_rr = (g + 1) % NB;
      end
      for (int i = 0; i < NB; i++) begin
        if (cap_strobe[i] && m_pend[i] && g != i) m_ovr[i] = 1'b1;
        else if (ovr_clr[i]) m_ovr[i] = 1'b0;
        if (cap_strobe[i]) begin
          m_hold[i] = captured[i*TW +: TW];
          m_pend[i] = 1'b1;
        end else if (g == i) begin
          m_pend[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_outputs();
    logic [IDX_W+TW-1:0] h;
    h = (m_q.size() > 0) ? m_q[0] : '0;
    chk_val("out_valid", out_valid, m_q.size() > 0);
    chk_val("out_idx", out_idx, h[TW +: IDX_W]);
    chk_val("out_value", out_value, h[TW-1:0]);
    chk_val("fifo_level", fifo_level, m_q.size());
    chk_val("fifo_full", fifo_full, m_q.size() == DEPTH);
    chk_val("overrun", overrun, m_ovr);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_outputs();
  endtask

  task automatic idle_inputs();
    rst        = 1'b0;
    cap_strobe = '0;
    ovr_clr    = '0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    cap_strobe = '0;
    ovr_clr    = '0;
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  initial begin
    int exp_n;
    int last_idx;
    int n_del;
    bit alt_ok;
    logic [IDX_W-1:0] exp_idx [11];
    logic [TW-1:0]    exp_val [11];

    rst = 1'b1;
    cap_strobe = '0;
    captured = '0;
    ovr_clr = '0;
    out_ready = 1'b0;

    // Reset state
    do_reset(2);
    chk_val("rst_valid", out_valid, 1'b0);
    chk_val("rst_level", fifo_level, 0);
    chk_val("rst_ovr", overrun, 0);

    // Single capture, two-clock latency
    cap_strobe[3] = 1'b1;
    set_slice(3, 32'h64);
    step();
    idle_inputs();
    chk_val("sc_lat1", out_valid, 1'b0);
    step();
    chk_val("sc_valid", out_valid, 1'b1);
    chk_val("sc_idx", out_idx, 3);
    chk_val("sc_val", out_value, 32'h64);
    chk_val("sc_lvl", fifo_level, 1);
    out_ready = 1'b1;
    step();
    chk_val("sc_drain_valid", out_valid, 1'b0);
    chk_val("sc_drain_lvl", fifo_level, 0);

    // Simultaneous strobes from all interfaces, delivered in index order
    do_reset(1);
    out_ready = 1'b1;
    for (int i = 0; i < NB; i++) set_slice(i, 100 + i);
    cap_strobe = '1;
    step();
    idle_inputs();
    exp_n = 0;
    repeat (14) begin
      step();
      if (out_valid) begin
        chk_val("sim_idx", out_idx, exp_n);
        chk_val("sim_val", out_value, 100 + exp_n);
        exp_n++;
      end
    end
    chk_val("sim_count", exp_n, NB);
    chk_val("sim_ovr", overrun, 0);

    // Backpressure to full, then overrun on interface 5, then drain
    do_reset(1);
    out_ready = 1'b0;
    for (int i = 0; i < NB; i++) set_slice(i, i * 7 + 1);
    cap_strobe = '1;
    step();
    idle_inputs();
    repeat (12) step();
    chk_val("bp_lvl", fifo_level, DEPTH);
    chk_val("bp_full", fifo_full, 1'b1);
    cap_strobe[5] = 1'b1;
    set_slice(5, 32'h10);
    step();
    chk_val("ovr_first", overrun[5], 1'b0);
    set_slice(5, 32'h20);
    step();
    idle_inputs();
    chk_val("ovr_set", overrun[5], 1'b1);
    for (int i = 0; i < NB; i++) begin
      exp_idx[i] = IDX_W'(i);
      exp_val[i] = i * 7 + 1;
    end
    exp_idx[10] = 5;
    exp_val[10] = 32'h20;
    out_ready = 1'b1;
    n_del = 0;
    repeat (16) begin
      if (out_valid && n_del < 11) begin
        chk_val("drain_idx", out_idx, exp_idx[n_del]);
        chk_val("drain_val", out_value, exp_val[n_del]);
        n_del++;
      end
      step();
    end
    chk_val("drain_count", n_del, 11);
    chk_val("drain_empty", out_valid, 1'b0);
    ovr_clr[5] = 1'b1;
    step();
    idle_inputs();
    chk_val("ovr_clr", overrun[5], 1'b0);

    // Round-robin fairness between interfaces 1 and 2
    do_reset(1);
    out_ready = 1'b1;
    last_idx = -1;
    n_del = 0;
    alt_ok = 1'b1;
    for (int c = 0; c < 24; c++) begin
      cap_strobe = '0;
      cap_strobe[1] = 1'b1;
      cap_strobe[2] = 1'b1;
      set_slice(1, 32'h1000 + c);
      set_slice(2, 32'h2000 + c);
      step();
      if (out_valid) begin
        if (int'(out_idx) == last_idx) alt_ok = 1'b0;
        last_idx = int'(out_idx);
        n_del++;
      end
    end
    idle_inputs();
    chk_val("rr_alternate", alt_ok, 1'b1);
    chk_val("rr_progress", n_del >= 20, 1'b1);
    repeat (4) step();

    // Reset mid-operation with queued and pending entries
    do_reset(1);
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cap_strobe[i] = 1'b1;
      set_slice(i, 32'hA0 + i);
    end
    step();
    idle_inputs();
    repeat (4) step();
    chk_val("mid_lvl", fifo_level, 4);
    cap_strobe[5] = 1'b1;
    step();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_val("mid_rst_lvl", fifo_level, 0);
    chk_val("mid_rst_valid", out_valid, 1'b0);
    chk_val("mid_rst_ovr", overrun, 0);
    cap_strobe[7] = 1'b1;
    set_slice(7, 32'hABCD);
    step();
    idle_inputs();
    chk_val("mid_lat1", out_valid, 1'b0);
    step();
    chk_val("mid_valid", out_valid, 1'b1);
    chk_val("mid_idx", out_idx, 7);
    chk_val("mid_val", out_value, 32'hABCD);

    // Random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < NB; i++) begin
        cap_strobe[i] = ($urandom_range(0, 5) == 0);
        ovr_clr[i]    = ($urandom_range(0, 19) == 0);
        set_slice(i, $urandom);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (20) step();
    chk_val("final_empty", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
